// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU constants, binary32 field struct, divider state
// encoding, special-result class and operand classification.
package fpu_pkg;

  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int QBITS    = 26;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} fdiv_state_t;

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} fp_class_t;

  // Result override chosen at operand decode; SP_NONE uses the datapath.
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

  // Denormals (exp 0) are treated as zero.
  function automatic fp_class_t classify(input fp32_t f);
    if (f.exp == '0)
      return CLS_ZERO;
    else if (f.exp == EXP_W'(EXP_MAX))
      return (f.mant == '0) ? CLS_INF : CLS_NAN;
    else
      return CLS_NORM;
  endfunction

endpackage

// File: rtl/fdiv_round.sv
// fdiv_round: combinational RNE rounding and result packing.
// Ports:
//   sign   - result sign
//   e      - biased result exponent before rounding (signed 10-bit)
//   q      - raw quotient, q[QBITS-1] is the hidden one
//   sticky - remainder non-zero
//   spec   - special-case override class
//   fin    - both operand exponents below 255
//   y      - packed binary32 result
//   ovf    - result exponent saturated with finite operands
module fdiv_round
  import fpu_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] e,
  input  logic [QBITS-1:0]  q,
  input  logic              sticky,
  input  spec_t             spec,
  input  logic              fin,
  output logic [31:0]       y,
  output logic              ovf
);

  logic [MANT_W-1:0] mant;
  logic              guard;
  logic              st;
  logic              inc;
  logic [MANT_W:0]   mant_sum;
  logic signed [9:0] e_r;
  logic              unused_msb;

  assign unused_msb = q[QBITS-1];

  always_comb begin
    mant     = q[QBITS-2:2];
    guard    = q[1];
    st       = q[0] | sticky;
    inc      = guard & (st | mant[0]);
    // Carry-out leaves mant_sum[MANT_W-1:0] at zero, which is the wanted mantissa.
    mant_sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    e_r      = e + $signed({9'd0, mant_sum[MANT_W]});

    y = '0;
    unique case (spec)
      SP_NAN:  y = QNAN;
      SP_INF:  y = {sign, 8'hFF, {MANT_W{1'b0}}};
      SP_ZERO: y = {sign, 31'd0};
      default: begin
        if (e_r >= 10'sd255)
          y = {sign, 8'hFF, {MANT_W{1'b0}}};
        else if (e_r <= 10'sd0)
          y = {sign, 31'd0};
        else
          y = {sign, e_r[7:0], mant_sum[MANT_W-1:0]};
      end
    endcase

    ovf = fin & (y[30:23] == 8'hFF);
  end

endmodule

// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative binary32 divider y = x1 / x2, radix-2 restoring,
// one quotient bit per cycle, constant latency for all operand classes.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - operand handshake (ready only when idle)
//   x1, x2              - dividend, divisor
//   out_valid, out_ready- result handshake
//   y, ovf, dbz         - quotient, overflow flag, divide-by-zero flag
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// DIV   | QBITS recurrence steps, counter 0..QBITS-1
// ROUND | round and register result
// DONE  | out_valid=1, hold result until out_ready
module fdiv_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        dbz
);

  fdiv_state_t state, state_nxt;

  fp32_t             a, b;
  fp_class_t         ca, cb;
  logic [MANT_W:0]   ma_in, mb_in;
  logic              norm_in;
  logic signed [9:0] e_in;
  spec_t             spec_in;
  logic              dbz_in;

  logic [4:0]        cnt;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [MANT_W:0]   mb_q;
  logic [MANT_W+1:0] rem_q;
  logic [QBITS-1:0]  q_q;
  spec_t             spec_q;
  logic              fin_q;
  logic              dbz_q;

  logic              ge;
  logic [MANT_W+1:0] rem_sub;
  logic [MANT_W+1:0] rem_nxt;
  logic [31:0]       y_rnd;
  logic              ovf_rnd;

  assign a  = x1;
  assign b  = x2;
  assign ca = classify(a);
  assign cb = classify(b);

  always_comb begin
    ma_in   = {1'b1, a.mant};
    mb_in   = {1'b1, b.mant};
    norm_in = (ma_in < mb_in);
    e_in    = $signed({2'b00, a.exp}) - $signed({2'b00, b.exp})
            + 10'sd127 - $signed({9'd0, norm_in});

    spec_in = SP_NONE;
    dbz_in  = 1'b0;
    if (ca == CLS_NAN || cb == CLS_NAN ||
        (ca == CLS_ZERO && cb == CLS_ZERO) ||
        (ca == CLS_INF && cb == CLS_INF))
      spec_in = SP_NAN;
    else if (ca == CLS_INF)
      spec_in = SP_INF;
    else if (cb == CLS_INF || ca == CLS_ZERO)
      spec_in = SP_ZERO;
    else if (cb == CLS_ZERO) begin
      spec_in = SP_INF;
      dbz_in  = 1'b1;
    end
  end

  // Remainder stays below 2*mb, so the shift after subtraction never overflows.
  always_comb begin
    ge      = (rem_q >= {1'b0, mb_q});
    rem_sub = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_nxt = {rem_sub[MANT_W:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = DIV;
      end
      DIV:   if (cnt == 5'(QBITS-1)) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sign_q <= 1'b0;
      exp_q  <= '0;
      mb_q   <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      spec_q <= SP_NONE;
      fin_q  <= 1'b0;
      dbz_q  <= 1'b0;
      y      <= '0;
      ovf    <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          cnt    <= '0;
          sign_q <= a.sign ^ b.sign;
          exp_q  <= e_in;
          mb_q   <= mb_in;
          rem_q  <= norm_in ? {ma_in, 1'b0} : {1'b0, ma_in};
          q_q    <= '0;
          spec_q <= spec_in;
          fin_q  <= (a.exp != 8'hFF) && (b.exp != 8'hFF);
          dbz_q  <= dbz_in;
        end
        DIV: begin
          rem_q <= rem_nxt;
          q_q   <= {q_q[QBITS-2:0], ge};
          cnt   <= cnt + 5'd1;
        end
        ROUND: begin
          y   <= y_rnd;
          ovf <= ovf_rnd;
          dbz <= dbz_q;
        end
        default: ;
      endcase
    end
  end

  fdiv_round u_round (
    .sign   (sign_q),
    .e      (exp_q),
    .q      (q_q),
    .sticky (rem_q != '0),
    .spec   (spec_q),
    .fin    (fin_q),
    .y      (y_rnd),
    .ovf    (ovf_rnd)
  );

endmodule

// File: tb/tb_fdiv_seq.sv
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1, x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;
  logic        dbz;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fdiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ey;
    logic        eovf;
    logic        edbz;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge. lat counts edges from the accept edge (inclusive)
  // to the edge after which out_valid is first seen.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ry, output logic rovf, output logic rdbz,
                       output int lat);
    int w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    x1 = a; x2 = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    ry = y; rovf = ovf; rdbz = dbz;
    @(posedge clk); #1;
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] de;
    de = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], de, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    int          es;
    logic [22:0] m;
    logic        g, st, inc;
    logic [23:0] ms;
    d   = $realtobits(f2r(a) / f2r(b));
    es  = int'(d[62:52]) - 1023 + 127;
    m   = d[51:29];
    g   = d[28];
    st  = |d[27:0];
    inc = g & (st | m[0]);
    ms  = {1'b0, m} + {23'd0, inc};
    es  = es + int'(ms[23]);
    if (es >= 255)     return {d[63], 8'hFF, 23'd0};
    else if (es <= 0)  return {d[63], 31'd0};
    else               return {d[63], es[7:0], ms[22:0]};
  endfunction

  initial begin
    logic [31:0] ry;
    logic        rovf, rdbz;
    logic [31:0] ea, eb, ey;
    int          lat;
    int          w;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0};
    vecs[2]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
    vecs[3]  = '{32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, 1'b1};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0};
    vecs[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 1'b0};
    vecs[6]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0};
    vecs[7]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0};
    vecs[8]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
    vecs[9]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0};
    vecs[10] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0};
    vecs[11] = '{32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1'b0};
    vecs[12] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0};
    vecs[13] = '{32'h3F800000, 32'h3F7FFFFF, 32'h3F800001, 1'b0, 1'b0};
    vecs[14] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 1'b0};
    vecs[15] = '{32'h3F800000, 32'h00000001, 32'h7F800000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x1 = '0; x2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y",         y,                  32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    chk("rst_dbz",       {31'd0, dbz},       32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].a, vecs[i].b, ry, rovf, rdbz, lat);
      chk($sformatf("v%0d_y", i),   ry,              vecs[i].ey);
      chk($sformatf("v%0d_ovf", i), {31'd0, rovf},   {31'd0, vecs[i].eovf});
      chk($sformatf("v%0d_dbz", i), {31'd0, rdbz},   {31'd0, vecs[i].edbz});
      chk($sformatf("v%0d_lat", i), lat,             32'd28);
      chk($sformatf("v%0d_in_ready_after_take", i), {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: result held, new operands waiting are not accepted.
    x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    chk("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
    x1 = 32'h3F800000; x2 = 32'h40400000; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_y_stable",  y,                     32'h40400000);
      chk("bp_in_ready",  {31'd0, in_ready},     32'd0);
      chk("bp_out_valid", {31'd0, out_valid},    32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_take_in_ready",  {31'd0, in_ready},  32'd1);
    chk("bp_take_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("bp_queued_accepted", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    chk("bp_queued_y", y, 32'h3EAAAAAB);
    @(posedge clk); #1;

    // Reset during DIV cycle 10 aborts the operation.
    x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst_y",         y,                  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(32'h40C00000, 32'h40000000, ry, rovf, rdbz, lat);
    chk("postrst_y",   ry,  32'h40400000);
    chk("postrst_lat", lat, 32'd28);

    // Random normal operands against a double-precision reference.
    for (int r = 0; r < 300; r++) begin
      ea = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      eb = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      ey = ref_div(ea, eb);
      do_op(ea, eb, ry, rovf, rdbz, lat);
      chk($sformatf("rnd%0d_y(%h/%h)", r, ea, eb), ry, ey);
      chk($sformatf("rnd%0d_ovf", r), {31'd0, rovf}, {31'd0, ey[30:23] == 8'hFF});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
